// File: rtl/mem_access_unit.sv
// Load/store sequencer between a CPU request port and a single-port synchronous RAM.
// Each access is one request -> one RAM phase -> one-cycle response pulse.
module mem_access_unit #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int READ_WAIT    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESS_SIZE-1:0] req_address,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    output logic                    resp_valid,
    output logic [DATA_SIZE-1:0]    resp_rdata,
    output logic                    mem_enable,
    output logic                    mem_read_write,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [DATA_SIZE-1:0]    mem_data_in,
    input  logic [DATA_SIZE-1:0]    mem_data_out,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       is_store;

    // NOTE: every output of this block gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_enable = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_write ? WRITE : READ;
            end
            WRITE: begin
                mem_enable = 1'b1;
                state_next = RESP;
            end
            READ: begin
                mem_enable = 1'b1;
                if (wait_cnt == 4'd0) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state is updated with <= so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= 4'd0;
            is_store       <= 1'b0;
            resp_rdata     <= '0;
            mem_read_write <= 1'b1;
            mem_address    <= '0;
            mem_data_in    <= '0;
            rd_count       <= 16'd0;
            wr_count       <= 16'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_read_write <= ~req_write;
                        mem_address    <= req_address;
                        mem_data_in    <= req_wdata;
                        is_store       <= req_write;
                        wait_cnt       <= 4'(READ_WAIT);
                    end
                end
                WRITE: begin
                    // Back to read direction as soon as the single write cycle ends.
                    mem_read_write <= 1'b1;
                end
                READ: begin
                    if (wait_cnt == 4'd0) resp_rdata <= mem_data_out;
                    else                  wait_cnt   <= wait_cnt - 4'd1;
                end
                RESP: begin
                    if (is_store) begin
                        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                    end else begin
                        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table-driven load/store vectors with a
// response scoreboard, plus hand sequences for reset abort, back-to-back and saturation.
module tb_mem_access_unit;

    localparam int RW = 1;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_enable, mem_read_write;
    logic [15:0] mem_address;
    logic [31:0] mem_data_in, mem_data_out;
    logic [15:0] rd_count, wr_count;

    logic        valid0, ready0, write0;
    logic [15:0] addr0;
    logic [31:0] wdata0;
    logic        resp_valid0;
    logic [31:0] resp_rdata0;
    logic        mem_enable0, mem_rw0;
    logic [15:0] mem_address0;
    logic [31:0] mem_data_in0, mem_data_out0;
    logic [15:0] rd_count0, wr_count0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic [31:0] ram[256];
    logic [15:0] m_rd = 16'd0;
    logic [15:0] m_wr = 16'd0;
    logic [31:0] last_rd = 32'd0;
    vec_t        vecs[10];

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_SIZE(32), .ADDRESS_SIZE(16), .READ_WAIT(RW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_enable(mem_enable), .mem_read_write(mem_read_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    mem_access_unit #(.DATA_SIZE(32), .ADDRESS_SIZE(16), .READ_WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(valid0), .req_ready(ready0), .req_write(write0),
        .req_address(addr0), .req_wdata(wdata0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .mem_enable(mem_enable0), .mem_read_write(mem_rw0),
        .mem_address(mem_address0), .mem_data_in(mem_data_in0), .mem_data_out(mem_data_out0),
        .rd_count(rd_count0), .wr_count(wr_count0)
    );

    // Simple RAM model; the second instance sees an address-derived pattern.
    always @(posedge clk) begin
        if (mem_enable && !mem_read_write) ram[mem_address[7:0]] <= mem_data_in;
    end
    assign mem_data_out  = ram[mem_address[7:0]];
    assign mem_data_out0 = 32'h1234_5678 ^ {16'd0, mem_address0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every response pulse pops one expected resp_rdata.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) check("resp_expected", 32'(sb.size()), 32'd1);
            else check("resp_rdata", resp_rdata, sb.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_txn(input vec_t v);
        int lat = 0, en = 0, wr = 0, ready_hi = 0;
        logic addr_ok = 1'b1, data_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_address = v.addr; req_wdata = v.wdata;
        for (int t = 0; t < 50 && !req_ready; t++) @(negedge clk);
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        sb.push_back(v.exp_rdata);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_enable) begin
                en++;
                if (!mem_read_write) wr++;
                if (mem_address !== v.addr) addr_ok = 1'b0;
                if (v.write && mem_data_in !== v.wdata) data_ok = 1'b0;
            end
            if (req_ready) ready_hi++;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), v.write ? 32'd2 : 32'(2 + RW));
        check("enabled_cycles", 32'(en), v.write ? 32'd1 : 32'(1 + RW));
        check("write_cycles", 32'(wr), v.write ? 32'd1 : 32'd0);
        check("addr_stable", {31'd0, addr_ok}, 32'd1);
        check("data_stable", {31'd0, data_ok}, 32'd1);
        check("ready_low_busy", 32'(ready_hi), 32'd0);
        if (v.write) begin
            if (m_wr != 16'hFFFF) m_wr++;
        end else begin
            if (m_rd != 16'hFFFF) m_rd++;
            last_rd = v.exp_rdata;
        end
        @(negedge clk);
        check("wr_count", {16'd0, wr_count}, {16'd0, m_wr});
        check("rd_count", {16'd0, rd_count}, {16'd0, m_rd});
    endtask

    initial begin
        int lat0, en0, first_ready, first_read, saw;
        int resp_k[$];
        vecs[0] = '{1'b1, 16'h0010, 32'h0000_00A5, 32'h0000_0000};
        vecs[1] = '{1'b0, 16'h0010, 32'h0,         32'h0000_00A5};
        vecs[2] = '{1'b1, 16'h0020, 32'hDEAD_BEEF, 32'h0000_00A5};
        vecs[3] = '{1'b0, 16'h0020, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 16'h0030, 32'h0,         32'h0000_0000};
        vecs[5] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6] = '{1'b0, 16'hFFFF, 32'h0,         32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 16'h0010, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[8] = '{1'b0, 16'h0010, 32'h0,         32'h0000_0001};
        vecs[9] = '{1'b0, 16'h0000, 32'h0,         32'h0000_0000};
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;

        // Reset with a simultaneous store request: reset must win.
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_address = 16'h1234; req_wdata = 32'h5555_AAAA;
        valid0 = 1'b0; write0 = 1'b0; addr0 = 16'd0; wdata0 = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_rw", {31'd0, mem_read_write}, 32'd1);
        check("rst_mem_address", {16'd0, mem_address}, 32'd0);
        check("rst_mem_data_in", mem_data_in, 32'd0);
        check("rst_counts", {rd_count, wr_count}, 32'd0);
        req_valid = 1'b0; reset = 1'b0;

        // Reset pulsed during READ aborts the load.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_address = 16'h0010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_read", {31'd0, mem_enable}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_enable", {31'd0, mem_enable}, 32'd0);
        check("abort_resp_rdata", resp_rdata, 32'd0);
        check("abort_counts", {rd_count, wr_count}, 32'd0);
        reset = 1'b0;
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw++;
        end
        check("abort_no_resp", 32'(saw), 32'd0);

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Store then load with req_valid held: load accepted on the first IDLE edge.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0040; req_wdata = 32'h5A5A_0001;
        sb.push_back(last_rd);
        sb.push_back(32'h5A5A_0001);
        for (int t = 0; t < 50 && !req_ready; t++) @(negedge clk);
        @(posedge clk);
        #1 req_write = 1'b0;
        first_ready = 0; first_read = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid) resp_k.push_back(k);
            if (mem_enable && mem_read_write && first_read == 0) first_read = k;
            if (req_ready && first_ready == 0) begin
                first_ready = k;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        check("b2b_first_ready", 32'(first_ready), 32'd3);
        check("b2b_first_read", 32'(first_read), 32'd4);
        check("b2b_resp_count", 32'(resp_k.size()), 32'd2);
        if (resp_k.size() == 2) begin
            check("b2b_store_resp", 32'(resp_k[0]), 32'd2);
            check("b2b_load_resp", 32'(resp_k[1]), 32'(5 + RW));
        end
        m_wr++; m_rd++; last_rd = 32'h5A5A_0001;
        check("b2b_wr_count", {16'd0, wr_count}, {16'd0, m_wr});
        check("b2b_rd_count", {16'd0, rd_count}, {16'd0, m_rd});

        // Saturation: preload the store counter near the top, then store past it.
        @(negedge clk);
        force dut.wr_count = 16'hFFFD;
        #1 release dut.wr_count;
        m_wr = 16'hFFFD;
        for (int i = 0; i < 3; i++) run_txn('{1'b1, 16'h0050 + 16'(i), 32'h0000_0100 + 32'(i), last_rd});

        // READ_WAIT = 0 instance: capture in the single READ cycle.
        @(negedge clk);
        valid0 = 1'b1; write0 = 1'b0; addr0 = 16'h0042;
        for (int t = 0; t < 50 && !ready0; t++) @(negedge clk);
        @(posedge clk);
        #1 valid0 = 1'b0;
        lat0 = 0; en0 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_enable0) en0++;
            if (resp_valid0) begin
                lat0 = k;
                check("rw0_rdata", resp_rdata0, 32'h1234_5678 ^ 32'h0000_0042);
                break;
            end
        end
        check("rw0_latency", 32'(lat0), 32'd2);
        check("rw0_enabled_cycles", 32'(en0), 32'd1);
        @(negedge clk);
        check("rw0_rd_count", {16'd0, rd_count0}, 32'd1);

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
